regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, for the multi-issue pipeline. It provides NREAD combinational read ports and NWRITE synchronous writeback ports, with same-cycle write-to-read bypass. A busy bit per register is set when an instruction allocates that register as its destination and cleared when the value is written back. The decode/issue stage uses the busy bits to stall on RAW hazards. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- WIDTH, 64, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥2).
- NREAD, 4, number of read ports.
- NWRITE, 2, number of writeback ports.
- NALLOC, 2, number of destination-allocation ports.
- AW, $clog2(NREGS), address width (derived).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ra  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd  out  NREAD*WIDTH  read data, combinational.
- rbusy  out  NREAD  busy flag for each read address, combinational.
- wen  in  NWRITE  per-port write enable.
- wa  in  NWRITE*AW  write addresses.
- wd  in  NWRITE*WIDTH  write data.
- alloc_en  in  NALLOC  per-port busy-set enable.
- alloc_addr  in  NALLOC*AW  register to mark busy.
- flush  in  1  clears every busy bit, for pipeline squash.

## Operation
- State: regs[NREGS] of WIDTH bits and busy[NREGS] of 1 bit.
- Write, next state: for each register r≠0, the highest-index write port j with wen[j] && wa[j]==r writes wd[j]. Lower-index writers to the same r are dropped. If no port matches, r holds its value.
- Writes to r=0 are ignored. regs[0] is always 0.
- Read: rd[i] = 0 if ra[i]==0; otherwise it is the next-state value of regs[ra[i]]. This means a same-cycle write is bypassed, using the same priority rule as the write.
- Busy clear: any wen[j] with wa[j]==r clears busy[r].
- Busy set: any alloc_en[k] with alloc_addr[k]==r sets busy[r].
- Set and clear on the same r in the same cycle: set wins, because a new producer supersedes the old one.
- flush: all busy bits go to 0 next cycle. It overrides alloc and clear, and has no effect on regs or writes.
- busy[0] is never set.
- rbusy[i] = busy[ra[i]] && !(any same-cycle write to ra[i]) && ra[i]≠0.
  - The clear is bypassed, consistent with the data bypass.
  - A same-cycle set is not visible until the next cycle.
- Duplicate alloc_addr values are legal and idempotent.

## Timing
- Reset: on reset falling, immediately and independently of clk, all regs = 0 and all busy = 0. While reset is low, rd = 0 and rbusy = 0 for every port, and writes and allocs are ignored.
- On reset release, the first rising edge with reset high performs normal updates.
- Reset asserted mid-operation discards any in-flight update. No partial state remains.
- Read latency: 0 cycles, combinational from ra, wen, wa and wd.
- Write latency: value visible on rd in the same cycle (bypass) and stored at the next rising edge.
- Busy latency:
  - A set at edge N is visible on rbusy after edge N.
  - A clear is visible in the same cycle as the write.
- Critical path: ra → NWRITE-way address compare → priority mux → rd. There must be no combinational path from alloc_en or flush to any output.

## Test plan
- Reset then reads: hold reset low, drive ra={1,2,31,0} → rd all 0, rbusy all 0. Release reset and read again → still 0.
- Write/bypass/priority:
  - Cycle 0: wen=2'b11, wa={5,5}, wd0=0x11, wd1=0x22, ra0=5 → rd0=0x22 in the same cycle.
  - Cycle 1, no writes → rd0=0x22.
  - Write to x0 with 0xFF → rd of x0 stays 0.
- Scoreboard:
  - alloc x7 at cycle 0 → rbusy for x7 is 0 in cycle 0 and 1 in cycle 1.
  - Cycle 3: wen with wa=7, wd=0xABC → rbusy 0 and rd=0xABC in cycle 3, and both stay so in cycle 4.
- Set/clear collision: x9 busy. In the same cycle, write x9 and alloc x9 → rbusy for x9 is 0 that cycle and 1 the next.
- Flush: alloc x3, x4 and x5 over successive cycles, then pulse flush together with alloc x6 → next cycle x3–x6 all not busy, and register data is unchanged.
- Async reset mid-run: registers hold non-zero values and x8 is busy. Drop reset between clock edges → rd and rbusy go to 0 before the next edge.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Reads are combinational with same-cycle writeback bypass; x0 reads zero and is never busy.
module regfile_mp #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 32,
    parameter int NREAD  = 4,
    parameter int NWRITE = 2,
    parameter int NALLOC = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*AW-1:0]      ra,
    output logic [NREAD*WIDTH-1:0]   rd,
    output logic [NREAD-1:0]         rbusy,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*AW-1:0]     wa,
    input  logic [NWRITE*WIDTH-1:0]  wd,
    input  logic [NALLOC-1:0]        alloc_en,
    input  logic [NALLOC*AW-1:0]     alloc_addr,
    input  logic                     flush
);

    logic [WIDTH-1:0] regs     [NREGS];
    logic [WIDTH-1:0] regs_nxt [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] alloc_hit;

    // Ascending port scan: the highest-index matching writer is the last to assign.
    always_comb begin
        wr_hit = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            regs_nxt[r] = regs[r];
            for (int unsigned j = 0; j < NWRITE; j++) begin
                if (wen[j] && (wa[j*AW +: AW] == AW'(r))) begin
                    regs_nxt[r] = wd[j*WIDTH +: WIDTH];
                    wr_hit[r]   = 1'b1;
                end
            end
        end
        regs_nxt[0] = '0;
    end

    always_comb begin
        alloc_hit = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            for (int unsigned k = 0; k < NALLOC; k++) begin
                if (alloc_en[k] && (alloc_addr[k*AW +: AW] == AW'(r))) begin
                    alloc_hit[r] = 1'b1;
                end
            end
        end
    end

    // A new producer supersedes the retiring one, so set is applied after clear.
    always_comb begin
        busy_nxt = (busy & ~wr_hit) | alloc_hit;
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs[r] <= regs_nxt[r];
            end
            busy <= busy_nxt;
        end
    end

    // Per-port compare against the write addresses keeps the read path short.
    always_comb begin
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] val;
        logic             hit;
        rd    = '0;
        rbusy = '0;
        addr  = '0;
        val   = '0;
        hit   = 1'b0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            addr = ra[i*AW +: AW];
            val  = regs[addr];
            hit  = 1'b0;
            for (int unsigned j = 0; j < NWRITE; j++) begin
                if (wen[j] && (wa[j*AW +: AW] == addr)) begin
                    val = wd[j*WIDTH +: WIDTH];
                    hit = 1'b1;
                end
            end
            if (reset && (addr != '0)) begin
                rd[i*WIDTH +: WIDTH] = val;
                rbusy[i]             = busy[addr] && !hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus a randomised phase
// checked against a behavioural model through an expectation queue.
module tb_regfile_mp;

    localparam int W  = 64;
    localparam int N  = 32;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int NA = 2;
    localparam int AW = 5;

    logic              clk;
    logic              reset;
    logic [NR*AW-1:0]  ra;
    logic [NR*W-1:0]   rd;
    logic [NR-1:0]     rbusy;
    logic [NW-1:0]     wen;
    logic [NW*AW-1:0]  wa;
    logic [NW*W-1:0]   wd;
    logic [NA-1:0]     alloc_en;
    logic [NA*AW-1:0]  alloc_addr;
    logic              flush;

    regfile_mp #(
        .WIDTH (W),
        .NREGS (N),
        .NREAD (NR),
        .NWRITE(NW),
        .NALLOC(NA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ra        (ra),
        .rd        (rd),
        .rbusy     (rbusy),
        .wen       (wen),
        .wa        (wa),
        .wd        (wd),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .flush     (flush)
    );

    typedef struct {
        string       tag;
        int          port;
        logic [63:0] exp_rd;
        logic        exp_busy;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] mreg [N];
    logic [N-1:0] mbusy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int port, input logic [63:0] e, input logic b);
        exp_t x;
        x.tag      = tag;
        x.port     = port;
        x.exp_rd   = e;
        x.exp_busy = b;
        q.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        #3;
        while (q.size() > 0) begin
            x = q.pop_front();
            check({x.tag, "_rd"}, rd[x.port*W +: W], x.exp_rd);
            check({x.tag, "_busy"}, 64'(rbusy[x.port]), 64'(x.exp_busy));
        end
    endtask

    task automatic set_ra(input int i, input logic [AW-1:0] a);
        ra[i*AW +: AW] = a;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [63:0] d);
        wen[j]         = 1'b1;
        wa[j*AW +: AW] = a;
        wd[j*W +: W]   = d;
    endtask

    task automatic set_al(input int k, input logic [AW-1:0] a);
        alloc_en[k]            = 1'b1;
        alloc_addr[k*AW +: AW] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wen      = '0;
        alloc_en = '0;
        flush    = 1'b0;
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, N - 1));
    endfunction

    task automatic rand_cycle(input int c);
        logic [AW-1:0] a;
        logic [63:0]   v;
        logic          hit;
        step();
        for (int j = 0; j < NW; j++) begin
            wen[j]         = ($urandom_range(0, 2) != 0);
            wa[j*AW +: AW] = pick();
            wd[j*W +: W]   = {$urandom, $urandom};
        end
        for (int k = 0; k < NA; k++) begin
            alloc_en[k]            = ($urandom_range(0, 1) == 1);
            alloc_addr[k*AW +: AW] = pick();
        end
        flush = ($urandom_range(0, 15) == 0);
        for (int i = 0; i < NR; i++) begin
            set_ra(i, pick());
        end
        for (int i = 0; i < NR; i++) begin
            a   = ra[i*AW +: AW];
            v   = mreg[a];
            hit = 1'b0;
            for (int j = 0; j < NW; j++) begin
                if (wen[j] && wa[j*AW +: AW] == a) begin
                    v   = wd[j*W +: W];
                    hit = 1'b1;
                end
            end
            if (a == 0) v = '0;
            push_exp($sformatf("rnd%0d_p%0d", c, i), i, v, (a != 0) && mbusy[a] && !hit);
        end
        drain();
        for (int j = 0; j < NW; j++) begin
            if (wen[j] && wa[j*AW +: AW] != 0) mreg[wa[j*AW +: AW]] = wd[j*W +: W];
        end
        for (int j = 0; j < NW; j++) begin
            if (wen[j]) mbusy[wa[j*AW +: AW]] = 1'b0;
        end
        for (int k = 0; k < NA; k++) begin
            if (alloc_en[k]) mbusy[alloc_addr[k*AW +: AW]] = 1'b1;
        end
        if (flush) mbusy = '0;
        mbusy[0] = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        ra         = '0;
        wen        = '0;
        wa         = '0;
        wd         = '0;
        alloc_en   = '0;
        alloc_addr = '0;
        flush      = 1'b0;

        // Reset held: reads zero even with a write and alloc presented.
        set_ra(0, 1); set_ra(1, 2); set_ra(2, 31); set_ra(3, 0);
        set_wr(0, 1, 64'h55);
        set_al(0, 2);
        #2;
        for (int i = 0; i < NR; i++) push_exp($sformatf("rst_lo%0d", i), i, 64'h0, 1'b0);
        drain();
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < NR; i++) push_exp($sformatf("rst_hold%0d", i), i, 64'h0, 1'b0);
        drain();
        step();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) push_exp($sformatf("rst_rel%0d", i), i, 64'h0, 1'b0);
        drain();

        // Write priority and bypass.
        step(); set_wr(0, 5, 64'h11); set_wr(1, 5, 64'h22); set_ra(0, 5);
        push_exp("byp", 0, 64'h22, 1'b0); drain();
        step(); push_exp("byp_hold", 0, 64'h22, 1'b0); drain();
        step(); set_wr(0, 0, 64'hFF); set_ra(0, 0);
        push_exp("x0_wr", 0, 64'h0, 1'b0); drain();
        step(); push_exp("x0_hold", 0, 64'h0, 1'b0); drain();
        step(); set_wr(0, 5, 64'h33); set_ra(0, 5);
        push_exp("p0_only", 0, 64'h33, 1'b0); drain();

        // Busy set and writeback clear.
        step(); set_al(0, 7); set_ra(1, 7);
        push_exp("al_c0", 1, 64'h0, 1'b0); drain();
        step(); push_exp("al_c1", 1, 64'h0, 1'b1); drain();
        step(); push_exp("al_c2", 1, 64'h0, 1'b1); drain();
        step(); set_wr(1, 7, 64'hABC);
        push_exp("wb_c3", 1, 64'hABC, 1'b0); drain();
        step(); push_exp("wb_c4", 1, 64'hABC, 1'b0); drain();

        // Same-cycle set and clear on one register.
        step(); set_al(1, 9); set_ra(2, 9);
        push_exp("col_a", 2, 64'h0, 1'b0); drain();
        step(); push_exp("col_busy", 2, 64'h0, 1'b1); drain();
        step(); set_wr(0, 9, 64'h99); set_al(1, 9);
        push_exp("col_same", 2, 64'h99, 1'b0); drain();
        step(); push_exp("col_next", 2, 64'h99, 1'b1); drain();

        // Flush clears busy but leaves data and writes alone.
        step(); set_wr(0, 3, 64'h3333); set_wr(1, 4, 64'h4444);
        step(); set_al(0, 3);
        step(); set_al(1, 4);
        step(); set_al(0, 5);
        step(); flush = 1'b1; set_al(0, 6); set_wr(0, 5, 64'h5555);
        set_ra(0, 3); set_ra(1, 4); set_ra(2, 5); set_ra(3, 6);
        push_exp("fl_x3", 0, 64'h3333, 1'b1);
        push_exp("fl_x4", 1, 64'h4444, 1'b1);
        push_exp("fl_x5", 2, 64'h5555, 1'b0);
        push_exp("fl_x6", 3, 64'h0, 1'b0);
        drain();
        step();
        push_exp("flq_x3", 0, 64'h3333, 1'b0);
        push_exp("flq_x4", 1, 64'h4444, 1'b0);
        push_exp("flq_x5", 2, 64'h5555, 1'b0);
        push_exp("flq_x6", 3, 64'h0, 1'b0);
        drain();

        // Asynchronous reset between edges.
        step(); set_al(0, 8); set_ra(0, 5); set_ra(1, 8);
        push_exp("ar_pre0", 1, 64'h0, 1'b0); drain();
        step();
        push_exp("ar_pre_x5", 0, 64'h5555, 1'b0);
        push_exp("ar_pre_x8", 1, 64'h0, 1'b1);
        drain();
        #1;
        reset = 1'b0;
        #1;
        push_exp("ar_lo_x5", 0, 64'h0, 1'b0);
        push_exp("ar_lo_x8", 1, 64'h0, 1'b0);
        drain();
        step(); step();
        reset = 1'b1;
        set_ra(0, 5); set_ra(1, 7); set_ra(2, 9); set_ra(3, 8);
        for (int i = 0; i < NR; i++) push_exp($sformatf("ar_rel%0d", i), i, 64'h0, 1'b0);
        drain();

        // Random traffic against the behavioural model, starting from reset state.
        for (int r = 0; r < N; r++) mreg[r] = '0;
        mbusy = '0;
        for (int c = 0; c < 300; c++) rand_cycle(c);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
